u_lsu_ctl: RTL and testbench

Multi-cycle load/store controller that sequences the core's data SRAM (sram1) port.
- Accepts one decoded load or store at a time from the core: base from rs1_o, imm, store data from rs2_o, rd_a.
- Computes the effective address, drives byte-lane strobes and data, waits for the synchronous read, then aligns and extends the load result.
- Returns the load result as a regfile write, or reports a fault; the core stalls on req_ready.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/u_lsu_align.sv | 45 ++++
 rtl/u_lsu_ctl.sv | 178 +++++++++++++++++
 tb/tb_u_lsu_ctl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {IDLE, ACC, WAIT, RESP, ERR} state_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      FC_NONE    = 2'b00,
      FC_MIS_LD  = 2'b01,
      FC_MIS_ST  = 2'b10,
      FC_ILLEGAL = 2'b11
   } fault_cause_e;

   // Access size is funct3[1:0]: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ea_lo);
      logic mis;
      case (size)
         2'b01:   mis = ea_lo[0];
         2'b10:   mis = (ea_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/u_lsu_align.sv
// Byte-lane mask, store-data replication and load extract/extend for the LSU.
module u_lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      ea_lo_i,
   input  logic [XLEN-1:0] st_data_i,
   input  logic [XLEN-1:0] rd_data_i,
   output logic [3:0]      mask_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] ldata_o
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      mask_o  = 4'b1111;
      wdata_o = st_data_i;
      ldata_o = '0;
      // Bring the addressed lane down to bit 0 before extending.
      shifted = rd_data_i >> {ea_lo_i, 3'b000};

      case (funct3_i[1:0])
         2'b00: begin
            mask_o  = 4'b0001 << ea_lo_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         2'b01: begin
            mask_o  = ea_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{st_data_i[15:0]}};
         end
         default: mask_o = 4'b1111;
      endcase

      case (funct3_i)
         F3_B:    ldata_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ldata_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    ldata_o = shifted;
         F3_BU:   ldata_o = {24'd0, shifted[7:0]};
         F3_HU:   ldata_o = {16'd0, shifted[15:0]};
         default: ldata_o = '0;
      endcase
   end

endmodule

// File: rtl/u_lsu_ctl.sv
// Multi-cycle load/store controller driving the data SRAM port.
// Optional LSU_PERF_CNT_EN adds saturating load/store/fault counters.
module u_lsu_ctl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_ld,
   input  logic              req_st,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   base,
   input  logic [XLEN-1:0]   imm,
   input  logic [XLEN-1:0]   st_data,
   input  logic [4:0]        rd_a,
   output logic [ADDR_W-1:0] dat_a,
   output logic [3:0]        dat_we,
   output logic [XLEN-1:0]   dat_wd,
   output logic [3:0]        dat_re,
   input  logic [XLEN-1:0]   dat_rd,
   output logic              wb_e,
   output logic [4:0]        wb_a,
   output logic [XLEN-1:0]   wb_d,
   output logic              done,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic [XLEN-1:0]   badaddr
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [XLEN-1:0]   ld_cnt,
   output logic [XLEN-1:0]   st_cnt,
   output logic [XLEN-1:0]   flt_cnt
`endif
);

   localparam int unsigned LAT_W = 2;

   state_e          state_q;
   logic [XLEN-1:0] ea_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] st_data_q;
   logic [4:0]      rd_q;
   logic            ld_q;
   fault_cause_e    cause_q;
   logic [LAT_W-1:0] wcnt_q;
   logic [4:0]      wb_a_q;
   logic [XLEN-1:0] wb_d_q;

   logic [XLEN-1:0] ea_d;
   logic            illegal_d;
   logic            misal_d;
   logic [3:0]      mask;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] ldata;

   assign ea_d      = base + imm;
   assign illegal_d = (req_ld == req_st)
                    || (req_ld && ((funct3 == 3'd3) || (funct3[2:1] == 2'b11)))
                    || (req_st && (funct3 >= 3'd3));
   assign misal_d   = is_misaligned(funct3[1:0], ea_d[1:0]);

   u_lsu_align u_align (
      .funct3_i  (f3_q),
      .ea_lo_i   (ea_q[1:0]),
      .st_data_i (st_data_q),
      .rd_data_i (dat_rd),
      .mask_o    (mask),
      .wdata_o   (wdata),
      .ldata_o   (ldata)
   );

   // Sequencer: request capture, read-latency wait and writeback history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ea_q      <= '0;
         f3_q      <= '0;
         st_data_q <= '0;
         rd_q      <= '0;
         ld_q      <= 1'b0;
         cause_q   <= FC_NONE;
         wcnt_q    <= '0;
         wb_a_q    <= '0;
         wb_d_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  ea_q      <= ea_d;
                  f3_q      <= funct3;
                  st_data_q <= st_data;
                  rd_q      <= rd_a;
                  ld_q      <= req_ld;
                  if (illegal_d) begin
                     state_q <= ERR;
                     cause_q <= FC_ILLEGAL;
                  end else if (misal_d) begin
                     state_q <= ERR;
                     cause_q <= req_ld ? FC_MIS_LD : FC_MIS_ST;
                  end else begin
                     state_q <= ACC;
                  end
               end
            end
            ACC: begin
               if (!ld_q) begin
                  state_q <= IDLE;
               end else if (RD_LAT <= 1) begin
                  state_q <= RESP;
               end else begin
                  state_q <= WAIT;
                  wcnt_q  <= LAT_W'(1);
               end
            end
            WAIT: begin
               if (wcnt_q >= LAT_W'(RD_LAT - 1)) begin
                  state_q <= RESP;
               end else begin
                  wcnt_q <= wcnt_q + LAT_W'(1);
               end
            end
            RESP: begin
               wb_a_q  <= rd_q;
               wb_d_q  <= ldata;
               state_q <= IDLE;
            end
            ERR: begin
               cause_q <= FC_NONE;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Port outputs are decoded from the state register; load data passes
   // straight from the SRAM in RESP and is held afterwards.
   assign req_ready   = (state_q == IDLE);
   assign dat_a       = (state_q == ACC) ? ea_q[ADDR_W+1:2] : '0;
   assign dat_we      = (state_q == ACC && !ld_q) ? mask : 4'b0000;
   assign dat_wd      = (state_q == ACC && !ld_q) ? wdata : '0;
   assign dat_re      = (state_q == ACC && ld_q) ? mask : 4'b0000;
   assign wb_e        = (state_q == RESP) && (rd_q != 5'd0);
   assign wb_a        = (state_q == RESP) ? rd_q : wb_a_q;
   assign wb_d        = (state_q == RESP) ? ldata : wb_d_q;
   assign done        = (state_q == RESP) || (state_q == ERR) || (state_q == ACC && !ld_q);
   assign fault       = (state_q == ERR);
   assign fault_cause = (state_q == ERR) ? cause_q : FC_NONE;
   assign badaddr     = (state_q == ERR) ? ea_q : '0;

`ifdef LSU_PERF_CNT_EN
   logic [XLEN-1:0] ld_cnt_q, st_cnt_q, flt_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_cnt_q  <= '0;
         st_cnt_q  <= '0;
         flt_cnt_q <= '0;
      end else begin
         if (state_q == RESP && ld_cnt_q != '1)
            ld_cnt_q <= ld_cnt_q + XLEN'(1);
         if (state_q == ACC && !ld_q && st_cnt_q != '1)
            st_cnt_q <= st_cnt_q + XLEN'(1);
         if (state_q == ERR && flt_cnt_q != '1)
            flt_cnt_q <= flt_cnt_q + XLEN'(1);
      end
   end

   assign ld_cnt  = ld_cnt_q;
   assign st_cnt  = st_cnt_q;
   assign flt_cnt = flt_cnt_q;
`endif

endmodule

// File: tb/tb_u_lsu_ctl.sv
// Directed bench for u_lsu_ctl: vector table on an RD_LAT=1 instance plus
// multi-cycle sequences on an RD_LAT=3 instance.
module tb_u_lsu_ctl;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid1, req_valid3;
   logic        req_ld, req_st;
   logic [2:0]  funct3;
   logic [31:0] base, imm, st_data;
   logic [4:0]  rd_a;
   logic [31:0] rdata_v;

   logic        req_ready1, wb_e1, done1, fault1;
   logic [15:0] dat_a1;
   logic [3:0]  dat_we1, dat_re1;
   logic [31:0] dat_wd1, dat_rd1, wb_d1, badaddr1;
   logic [4:0]  wb_a1;
   logic [1:0]  fault_cause1;

   logic        req_ready3, wb_e3, done3, fault3;
   logic [15:0] dat_a3;
   logic [3:0]  dat_we3, dat_re3;
   logic [31:0] dat_wd3, dat_rd3, wb_d3, badaddr3;
   logic [4:0]  wb_a3;
   logic [1:0]  fault_cause3;

   u_lsu_ctl #(.ADDR_W(16), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_ld(req_ld), .req_st(req_st), .funct3(funct3), .base(base), .imm(imm),
      .st_data(st_data), .rd_a(rd_a), .dat_a(dat_a1), .dat_we(dat_we1),
      .dat_wd(dat_wd1), .dat_re(dat_re1), .dat_rd(dat_rd1), .wb_e(wb_e1),
      .wb_a(wb_a1), .wb_d(wb_d1), .done(done1), .fault(fault1),
      .fault_cause(fault_cause1), .badaddr(badaddr1)
   );

   u_lsu_ctl #(.ADDR_W(16), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_ld(req_ld), .req_st(req_st), .funct3(funct3), .base(base), .imm(imm),
      .st_data(st_data), .rd_a(rd_a), .dat_a(dat_a3), .dat_we(dat_we3),
      .dat_wd(dat_wd3), .dat_re(dat_re3), .dat_rd(dat_rd3), .wb_e(wb_e3),
      .wb_a(wb_a3), .wb_d(wb_d3), .done(done3), .fault(fault3),
      .fault_cause(fault_cause3), .badaddr(badaddr3)
   );

   // SRAM models: data is valid only RD_LAT cycles after a read strobe.
   logic        vp1;
   logic [31:0] dp1;
   logic [2:0]  vp3;
   logic [31:0] dp3 [3];

   always @(posedge clk) begin
      vp1    <= (dat_re1 != 4'd0);
      dp1    <= rdata_v;
      vp3    <= {vp3[1:0], (dat_re3 != 4'd0)};
      dp3[0] <= rdata_v;
      dp3[1] <= dp3[0];
      dp3[2] <= dp3[1];
   end
   assign dat_rd1 = vp1    ? dp1    : 32'h5A5A5A5A;
   assign dat_rd3 = vp3[2] ? dp3[2] : 32'h5A5A5A5A;

   int re3_cnt;
   always @(negedge clk) if (dat_re3 != 4'd0) re3_cnt <= re3_cnt + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] base, imm, sd;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          kind;
      logic [15:0] exp_a;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wd, exp_wbd;
      logic [1:0]  exp_cause;
      logic [31:0] exp_bad;
   } vec_t;

   function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] b,
                               logic [31:0] i, logic [31:0] sd, logic [4:0] rd,
                               logic [31:0] rdat, int kind, logic [15:0] a,
                               logic [3:0] strb, logic [31:0] wd, logic [31:0] wbd,
                               logic [1:0] cause, logic [31:0] bad);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.base = b; v.imm = i; v.sd = sd; v.rd = rd;
      v.rdata = rdat; v.kind = kind; v.exp_a = a; v.exp_strb = strb; v.exp_wd = wd;
      v.exp_wbd = wbd; v.exp_cause = cause; v.exp_bad = bad;
      return v;
   endfunction

   task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] b, input logic [31:0] i,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdat);
      req_ld = ld; req_st = st; funct3 = f3; base = b; imm = i;
      st_data = sd; rd_a = rd; rdata_v = rdat;
   endtask

   vec_t vecs[$];
   vec_t v;

   initial begin
      rst = 1'b1; req_valid1 = 1'b0; req_valid3 = 1'b0; re3_cnt = 0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);

      // kind: 0 store, 1 load, 2 fault
      vecs.push_back(mk(0,1,3'd2,32'h100,32'h4,32'hDEADBEEF,0,0,          0,16'h41,4'hF,32'hDEADBEEF,0,2'd0,0));
      vecs.push_back(mk(0,1,3'd0,32'h100,32'h3,32'h00000055,0,0,          0,16'h40,4'h8,32'h55555555,0,2'd0,0));
      vecs.push_back(mk(0,1,3'd1,32'h200,32'h2,32'h1234ABCD,0,0,          0,16'h80,4'hC,32'hABCDABCD,0,2'd0,0));
      vecs.push_back(mk(0,1,3'd2,32'hFFFFFFFC,32'h8,32'h01020304,0,0,     0,16'h1,4'hF,32'h01020304,0,2'd0,0));
      vecs.push_back(mk(0,1,3'd2,32'h12340010,32'h0,32'h000000A5,0,0,     0,16'h4,4'hF,32'h000000A5,0,2'd0,0));
      vecs.push_back(mk(1,0,3'd0,32'h200,32'h2,0,5'd5,32'h00800000,       1,16'h80,4'h4,0,32'hFFFFFF80,2'd0,0));
      vecs.push_back(mk(1,0,3'd4,32'h200,32'h2,0,5'd6,32'h00800000,       1,16'h80,4'h4,0,32'h00000080,2'd0,0));
      vecs.push_back(mk(1,0,3'd1,32'h300,32'hFFFFFFFE,0,5'd7,32'h80017FFF,1,16'hBF,4'hC,0,32'hFFFF8001,2'd0,0));
      vecs.push_back(mk(1,0,3'd5,32'h300,32'h0,0,5'd8,32'h8001F00D,       1,16'hC0,4'h3,0,32'h0000F00D,2'd0,0));
      vecs.push_back(mk(1,0,3'd2,32'h10,32'h10,0,5'd31,32'h12345678,      1,16'h8,4'hF,0,32'h12345678,2'd0,0));
      vecs.push_back(mk(1,0,3'd2,32'h40,32'h0,0,5'd0,32'h11111111,        1,16'h10,4'hF,0,32'h11111111,2'd0,0));
      vecs.push_back(mk(1,0,3'd0,32'h103,32'h0,0,5'd3,32'h7F000000,       1,16'h40,4'h8,0,32'h0000007F,2'd0,0));
      vecs.push_back(mk(1,0,3'd1,32'h100,32'h1,0,5'd1,0,                  2,0,0,0,0,2'b01,32'h101));
      vecs.push_back(mk(0,1,3'd2,32'h100,32'h2,32'h1,0,0,                 2,0,0,0,0,2'b10,32'h102));
      vecs.push_back(mk(1,1,3'd2,32'h0,32'h0,0,5'd1,0,                    2,0,0,0,0,2'b11,32'h0));
      vecs.push_back(mk(0,0,3'd2,32'h100,32'h2,0,5'd1,0,                  2,0,0,0,0,2'b11,32'h102));
      vecs.push_back(mk(1,0,3'd2,32'h100,32'h3,0,5'd1,0,                  2,0,0,0,0,2'b01,32'h103));
      vecs.push_back(mk(1,0,3'd3,32'h100,32'h0,0,5'd1,0,                  2,0,0,0,0,2'b11,32'h100));
      vecs.push_back(mk(0,1,3'd4,32'h104,32'h0,0,5'd1,0,                  2,0,0,0,0,2'b11,32'h104));

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready",  32'(req_ready1),   32'd1);
      chk("rst_done",   32'(done1),        32'd0);
      chk("rst_strb",   32'({dat_we1, dat_re1}), 32'd0);
      chk("rst_dat_a",  32'(dat_a1),       32'd0);
      chk("rst_wb",     32'({wb_e1, wb_a1}), 32'd0);
      chk("rst_wb_d",   wb_d1,             32'd0);
      chk("rst_fault",  32'({fault1, fault_cause1}), 32'd0);
      chk("rst_bad",    badaddr1,          32'd0);
      chk("rst_ready3", 32'(req_ready3),   32'd1);

      foreach (vecs[k]) begin
         v = vecs[k];
         @(negedge clk);
         chk("idle_ready", 32'(req_ready1), 32'd1);
         drive(v.ld, v.st, v.f3, v.base, v.imm, v.sd, v.rd, v.rdata);
         req_valid1 = 1'b1;
         @(negedge clk);
         req_valid1 = 1'b0;
         chk("busy_ready", 32'(req_ready1), 32'd0);
         case (v.kind)
            0: begin
               chk("st_dat_a",  32'(dat_a1),  32'(v.exp_a));
               chk("st_we",     32'(dat_we1), 32'(v.exp_strb));
               chk("st_wd",     dat_wd1,      v.exp_wd);
               chk("st_re",     32'(dat_re1), 32'd0);
               chk("st_done",   32'({done1, fault1, wb_e1}), 32'b100);
            end
            1: begin
               chk("ld_dat_a",  32'(dat_a1),  32'(v.exp_a));
               chk("ld_re",     32'(dat_re1), 32'(v.exp_strb));
               chk("ld_we",     32'(dat_we1), 32'd0);
               chk("ld_acc_done", 32'(done1), 32'd0);
               @(negedge clk);
               chk("ld_resp_re",  32'(dat_re1), 32'd0);
               chk("ld_resp_done", 32'({done1, fault1}), 32'b10);
               chk("ld_wb_e",   32'(wb_e1),   32'(v.rd != 5'd0));
               chk("ld_wb_a",   32'(wb_a1),   32'(v.rd));
               chk("ld_wb_d",   wb_d1,        v.exp_wbd);
            end
            default: begin
               chk("flt_flags", 32'({done1, fault1, wb_e1}), 32'b110);
               chk("flt_cause", 32'(fault_cause1), 32'(v.exp_cause));
               chk("flt_bad",   badaddr1,     v.exp_bad);
               chk("flt_strb",  32'({dat_we1, dat_re1}), 32'd0);
            end
         endcase
         @(negedge clk);
         chk("end_ready", 32'(req_ready1), 32'd1);
         chk("end_done",  32'({done1, wb_e1, fault1}), 32'd0);
         if (v.kind == 1) chk("wb_d_hold", wb_d1, v.exp_wbd);
      end

      // Back-to-back stores with req_valid held high on the RD_LAT=1 instance.
      @(negedge clk);
      drive(1'b0, 1'b1, 3'd2, 32'h0, 32'h0, 32'h1, 5'd0, 32'd0);
      req_valid1 = 1'b1;
      @(negedge clk);
      chk("b2b_done1", 32'({done1, req_ready1}), 32'b10);
      @(negedge clk);
      chk("b2b_gap",   32'({done1, req_ready1}), 32'b01);
      @(negedge clk);
      req_valid1 = 1'b0;
      chk("b2b_done2", 32'({done1, req_ready1}), 32'b10);
      @(negedge clk);
      chk("b2b_idle",  32'({done1, req_ready1}), 32'b01);

      // RD_LAT=3: LW to x0, single read strobe, done at accept+4, no writeback.
      @(negedge clk);
      re3_cnt = 0;
      drive(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 5'd0, 32'hCAFEF00D);
      req_valid3 = 1'b1;
      @(negedge clk);
      req_valid3 = 1'b0;
      chk("l3_re", 32'(dat_re3), 32'hF);
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         chk("l3_wait_done", 32'({done3, dat_re3}), 32'd0);
      end
      @(negedge clk);
      chk("l3_done", 32'({done3, wb_e3}), 32'b10);
      chk("l3_wb_d", wb_d3, 32'hCAFEF00D);
      @(negedge clk);
      chk("l3_ready", 32'({req_ready3, done3}), 32'b10);
      chk("l3_re_count", 32'(re3_cnt), 32'd1);

      // RD_LAT=3: LH upper half, sign-extended.
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd1, 32'h0, 32'h2, 32'h0, 5'd9, 32'h87650000);
      req_valid3 = 1'b1;
      @(negedge clk);
      req_valid3 = 1'b0;
      chk("h3_re", 32'(dat_re3), 32'hC);
      repeat (3) @(negedge clk);
      chk("h3_wb", 32'({done3, wb_e3, wb_a3}), 32'({1'b1, 1'b1, 5'd9}));
      chk("h3_wb_d", wb_d3, 32'hFFFF8765);
      @(negedge clk);

      // Reset while waiting on the read: no completion must follow.
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd2, 32'h80, 32'h0, 32'h0, 5'd4, 32'h0BADF00D);
      req_valid3 = 1'b1;
      @(negedge clk);
      req_valid3 = 1'b0;
      chk("r3_acc_re", 32'(dat_re3), 32'hF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("r3_ready", 32'(req_ready3), 32'd1);
      chk("r3_flags", 32'({done3, wb_e3, fault3}), 32'd0);
      chk("r3_wb_d",  wb_d3, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("r3_no_done", 32'({done3, wb_e3, req_ready3}), 32'b001);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
